// File: rtl/add_32_issue_pkg.sv
// Shared types and constants for the add_32_issue stage.
// Op encodings, flag bit positions and the S1 operand bundle.
package add_32_issue_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } s1_t;

endpackage

// File: rtl/add_32_issue_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// Ports: a, b, c_in in; sum, c_out out. Purely combinational.
module add_32_issue_cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = c_in;
    for (int j = 0; j < 8; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+4] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
               | (&p[4*j +: 4] & c[4*j]);
    end
  end

  assign sum   = p ^ c[31:0];
  assign c_out = c[32];

endmodule

// File: rtl/add_32_issue.sv
// Two-stage valid/ready ADD/SUB/ADC/SBC issue + writeback around the CLA.
// Ports: clk, rst, in_* request, carry_clr, out_* result, carry_q flag.
module add_32_issue
  import add_32_issue_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         carry_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic [3:0]   out_flags,
  output logic         carry_q
);

  logic        s1_valid;
  logic        s2_valid;
  s1_t         s1_q;
  logic        s1_adv;
  logic [31:0] b_eff;
  logic        cin;
  logic [31:0] sum;
  logic        c_out;
  logic [3:0]  flg;

  assign s1_adv    = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;

  // carry_q here is the carry of the op that last left S1,
  // i.e. the one immediately ahead in program order.
  always_comb begin
    b_eff = s1_q.b;
    cin   = 1'b0;
    unique case (s1_q.op)
      OP_ADD: ;
      OP_SUB: begin b_eff = ~s1_q.b; cin = 1'b1; end
      OP_ADC: cin = carry_q;
      OP_SBC: begin b_eff = ~s1_q.b; cin = carry_q; end
    endcase
  end

  add_32_issue_cla u_cla_32 (
    .a     (s1_q.a),
    .b     (b_eff),
    .c_in  (cin),
    .sum   (sum),
    .c_out (c_out)
  );

  always_comb begin
    flg        = '0;
    flg[FLG_Z] = (sum == '0);
    flg[FLG_N] = sum[31];
    flg[FLG_C] = c_out;
    flg[FLG_V] = (s1_q.a[31] == b_eff[31]) && (sum[31] != s1_q.a[31]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_q      <= '0;
      out_sum   <= '0;
      out_flags <= '0;
      carry_q   <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_q.op <= op_e'(in_op);
        s1_q.a  <= in_a;
        s1_q.b  <= in_b;
      end
      if (s1_adv) begin
        s2_valid  <= 1'b1;
        out_sum   <= sum;
        out_flags <= flg;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
      if (carry_clr)   carry_q <= 1'b0;
      else if (s1_adv) carry_q <= c_out;
    end
  end

endmodule

// File: tb/tb_add_32_issue.sv
// Scoreboard bench for add_32_issue: directed corners + random traffic.
// Expected results come from an arithmetic model pushed at accept time.
module tb_add_32_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        carry_clr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [3:0]  out_flags;
  logic        carry_q;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [35:0] sb[$];
  logic        model_carry = 1'b0;
  int          ready_mode = 0;
  logic        hold = 1'b0;
  logic [35:0] held;

  always #5 clk = ~clk;

  add_32_issue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .carry_clr (carry_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags),
    .carry_q   (carry_q)
  );

  task automatic check(input string name, input logic [35:0] got,
                       input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; signed overflow from range test.
  task automatic model(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [35:0] r);
    longint unsigned u;
    longint          sr;
    logic [31:0]     bb;
    logic [31:0]     s;
    logic            c;
    logic            v;
    int              ci;
    bb = (op == 2'd1 || op == 2'd3) ? ~b : b;
    ci = (op == 2'd0) ? 0 : (op == 2'd1) ? 1 : int'(model_carry);
    u  = longint'(a) + longint'(bb) + longint'(ci);
    s  = u[31:0];
    c  = u[32];
    sr = longint'($signed(a)) + longint'($signed(bb)) + longint'(ci);
    v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r  = {s, (s == 32'd0), s[31], c, v};
    model_carry = c;
  endtask

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    logic [35:0] e;
    if (rst) begin
      hold = 1'b0;
    end else if (out_valid) begin
      if (hold) check("hold_stable", {out_sum, out_flags}, held);
      if (out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_result: got %h expected none",
                   {out_sum, out_flags});
        end else begin
          e = sb.pop_front();
          check("result", {out_sum, out_flags}, e);
        end
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        held = {out_sum, out_flags};
      end
    end else begin
      hold = 1'b0;
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    int          t = 0;
    logic [35:0] r;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 36'(in_ready), 36'd1);
      in_valid = 1'b0;
      return;
    end
    model(op, a, b, r);
    sb.push_back(r);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 50);
    if (!out_valid) check("valid_timeout", 36'(out_valid), 36'd1);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("drain_empty", 36'(sb.size()), 36'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c [6];
    c[0] = 32'h0;
    c[1] = 32'hFFFF_FFFF;
    c[2] = 32'h8000_0000;
    c[3] = 32'h7FFF_FFFF;
    c[4] = 32'h1;
    c[5] = 32'h0;
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_a      = '0;
    in_b      = '0;
    carry_clr = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 36'(out_valid), 36'd0);
    check("rst_in_ready", 36'(in_ready), 36'd1);
    check("rst_carry", 36'(carry_q), 36'd0);
    check("rst_sum", 36'(out_sum), 36'd0);
    check("rst_flags", 36'(out_flags), 36'd0);
    @(posedge clk);
    #1;

    // ADD wrap: latency and flags
    send(2'd0, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    check("lat_not_yet", 36'(out_valid), 36'd0);
    @(negedge clk);
    check("lat_valid", 36'(out_valid), 36'd1);
    check("add_wrap", {out_sum, out_flags}, {32'h0, 4'b1010});
    drain();

    // SUB overflow
    send(2'd1, 32'h8000_0000, 32'h1);
    wait_valid();
    check("sub_ovf", {out_sum, out_flags}, {32'h7FFF_FFFF, 4'b0011});
    drain();

    // carry chaining back-to-back
    send(2'd0, 32'hFFFF_FFFF, 32'h1);
    send(2'd2, 32'h0, 32'h0);
    wait_valid();
    @(posedge clk);
    wait_valid();
    check("adc_chain", 36'(out_sum), 36'd1);
    drain();
    send(2'd0, 32'hFFFF_FFFF, 32'h1);
    drain();
    @(negedge clk);
    check("carry_set", 36'(carry_q), 36'd1);
    @(posedge clk);
    #1;
    carry_clr = 1'b1;
    @(posedge clk);
    #1;
    carry_clr   = 1'b0;
    model_carry = 1'b0;
    @(negedge clk);
    check("carry_clr_idle", 36'(carry_q), 36'd0);
    @(posedge clk);
    #1;
    send(2'd2, 32'h5, 32'h3);
    wait_valid();
    check("adc_after_clr", 36'(out_sum), 36'd8);
    drain();

    // back-pressure stall
    ready_mode = 2;
    out_ready  = 1'b1;
    fork
      begin
        send(2'd0, 32'd10, 32'd20);
        send(2'd1, 32'd50, 32'd7);
        send(2'd2, 32'hFFFF_FFF0, 32'h20);
        send(2'd3, 32'd3, 32'd5);
      end
      begin
        wait_valid();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 36'(in_ready), 36'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    ready_mode = 0;
    drain();

    // reset with both stages full
    ready_mode = 2;
    out_ready  = 1'b0;
    send(2'd0, 32'hFFFF_FFFF, 32'h1);
    send(2'd0, 32'd1, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    model_carry = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 36'(out_valid), 36'd0);
    check("mid_rst_ready", 36'(in_ready), 36'd1);
    check("mid_rst_carry", 36'(carry_q), 36'd0);
    check("mid_rst_sum", 36'(out_sum), 36'd0);
    ready_mode = 0;
    @(posedge clk);
    #1;

    // carry_clr beats a same-cycle carry update
    send(2'd0, 32'hFFFF_FFFF, 32'h1);
    carry_clr = 1'b1;
    @(posedge clk);
    #1;
    carry_clr   = 1'b0;
    model_carry = 1'b0;
    @(negedge clk);
    check("clr_priority", 36'(carry_q), 36'd0);
    @(posedge clk);
    #1;
    send(2'd2, 32'h5, 32'h3);
    drain();

    // random traffic with random back-pressure
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(2'($urandom_range(0, 3)), pick(), pick());
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    ready_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
